branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  ID-stage hazard controller for the early branch comparator. Produces the
//  comparator forward selects (fwd_cmp_a/fwd_cmp_b) and sequences F/D stalls
//  and the E bubble when a branch/jr source is not yet available.
//  Sits beside the decode-stage hazard logic; its outputs drive the comparator
//  and the IF/ID and ID/EX pipeline registers.
// PARAMETERS
//  REG_AW  5   register-number width
//  BR_W    3   width of branch_d (0 = not a branch)
//  CNT_W   32  width of stall_cycles performance counter
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  rs_d, rt_d    in   REG_AW  source registers of instruction in ID
//  branch_d      in   BR_W    branch kind (1 beq, 2 bne: use rs+rt; 3,4,6: rs only)
//  jr_d          in   1       jr in ID (uses rs only)
//  writereg_e    in   REG_AW  destination register in EX
//  regwrite_e    in   1       EX instruction writes
//  memtoreg_e    in   1       EX instruction is a load
//  writereg_m    in   REG_AW  destination register in MEM
//  regwrite_m    in   1       MEM instruction writes
//  memtoreg_m    in   1       MEM instruction is a load
//  writereg_w    in   REG_AW  destination register in WB
//  regwrite_w    in   1       WB instruction writes
//  fwd_cmp_a     out  2       00 regfile, 01 resultW, 10 alu_outM (for rs)
//  fwd_cmp_b     out  2       same encoding, for rt
//  stall_f       out  1       hold PC
//  stall_d       out  1       hold IF/ID
//  flush_e       out  1       insert bubble into ID/EX
//  stall_cycles  out  CNT_W   count of cycles with stall_d=1
// BEHAVIOUR
//  - Reset (async, rst=1): state=RUN, hold_cnt=0, stall_cycles=0; stall_f,
//    stall_d, flush_e=0. Forward selects are combinational and not reset.
//  - use_rs = branch_d!=0 | jr_d; use_rt = branch_d==1 | branch_d==2.
//    Register 0 never causes a hazard or a forward.
//  - Forward select (combinational, evaluated every cycle including during stalls):
//    10 if regwrite_m & ~memtoreg_m & writereg_m==src; else 01 if regwrite_w &
//    writereg_w==src; else 00. MEM wins over WB.
//  - Need n (RUN only), max over used sources:
//    n=2 if regwrite_e & memtoreg_e & writereg_e==src;
//    n=1 if regwrite_e & ~memtoreg_e & writereg_e==src;
//    n=1 if regwrite_m & memtoreg_m & writereg_m==src; else n=0.
//  - FSM states RUN, HOLD; registered hold_cnt (2 bits).
//    RUN, n=0: no stall.
//    RUN, n>=1: stall_f=stall_d=flush_e=1 this cycle (combinational);
//      if n=2 -> HOLD with hold_cnt=1, else stay RUN.
//    HOLD: stall_f=stall_d=flush_e=1, hazard inputs ignored; hold_cnt
//      decrements; when hold_cnt==1 at edge -> RUN.
//  - Worst case: load in EX feeding beq -> exactly 2 stall cycles; branch
//    resolves on 3rd cycle with fwd=01.
//  - stall_cycles += 1 on every edge where stall_d=1; wraps at 2^CNT_W.
//  - rst asserted in HOLD: immediate return to RUN, stalls drop asynchronously.
//  - Non-branch instructions in ID never stall here (load-use for ALU operands
//    belongs to the main hazard unit).
// TESTING
//  1 beq rs=8,rt=9; EX: regwrite_e=1,writereg_e=8,memtoreg_e=0 -> 1 stall
//    cycle; next cycle (producer in MEM) fwd_cmp_a=10, fwd_cmp_b=00, no stall.
//  2 bne rs=4; EX load writereg_e=4 -> stall 2 cycles (RUN->HOLD->RUN),
//    3rd cycle fwd_cmp_a=01; stall_cycles increments by 2.
//  3 jr rs=31; MEM ALU writereg_m=31 and WB writereg_w=31 -> fwd_cmp_a=10,
//    no stall.
//  4 beq rs=0,rt=0 with every stage writing reg 0 -> fwd 00/00, no stall.
//  5 branch_d=3 rs=5, rt=6; EX ALU writes 6 -> no stall (rt unused), fwd_b=00.
//  6 rst=1 asynchronously while in HOLD -> stall_* =0 before next edge,
//    stall_cycles=0, state RUN.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_hazard_ctrl
// Description : ID-stage hazard control for the early branch comparator:
//               comparator forward selects plus F/D stall and E bubble sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int BR_W   = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [BR_W-1:0]   branch_d,
    input  logic              jr_d,
    input  logic [REG_AW-1:0] writereg_e,
    input  logic              regwrite_e,
    input  logic              memtoreg_e,
    input  logic [REG_AW-1:0] writereg_m,
    input  logic              regwrite_m,
    input  logic              memtoreg_m,
    input  logic [REG_AW-1:0] writereg_w,
    input  logic              regwrite_w,
    output logic [1:0]        fwd_cmp_a,
    output logic [1:0]        fwd_cmp_b,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [0:0] c_RUN  = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [1:0]       r_hold_cnt;
    logic [1:0]       w_next_hold_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_use_rs;
    logic             w_use_rt;
    logic [1:0]       w_need_rs;
    logic [1:0]       w_need_rt;
    logic [1:0]       w_need;
    logic             w_stall;

    // Comparator forward source: ALU result in MEM beats the WB result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wr_m, input logic rw_m, input logic ld_m,
        input logic [REG_AW-1:0] wr_w, input logic rw_w
    );
        if (src == '0)                         return 2'b00;
        else if (rw_m && !ld_m && wr_m == src) return 2'b10;
        else if (rw_w && wr_w == src)          return 2'b01;
        else                                   return 2'b00;
    endfunction

    // Cycles this source must wait before a forward path can supply it.
    function automatic logic [1:0] need_of(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wr_e, input logic rw_e, input logic ld_e,
        input logic [REG_AW-1:0] wr_m, input logic rw_m, input logic ld_m
    );
        if (!used || src == '0)               return 2'd0;
        else if (rw_e && wr_e == src)         return ld_e ? 2'd2 : 2'd1;
        else if (rw_m && ld_m && wr_m == src) return 2'd1;
        else                                  return 2'd0;
    endfunction

    assign w_use_rs  = (branch_d != '0) || jr_d;
    assign w_use_rt  = (branch_d == BR_W'(1)) || (branch_d == BR_W'(2));
    assign fwd_cmp_a = fwd_sel(rs_d, writereg_m, regwrite_m, memtoreg_m, writereg_w, regwrite_w);
    assign fwd_cmp_b = fwd_sel(rt_d, writereg_m, regwrite_m, memtoreg_m, writereg_w, regwrite_w);
    assign w_need_rs = need_of(w_use_rs, rs_d, writereg_e, regwrite_e, memtoreg_e,
                               writereg_m, regwrite_m, memtoreg_m);
    assign w_need_rt = need_of(w_use_rt, rt_d, writereg_e, regwrite_e, memtoreg_e,
                               writereg_m, regwrite_m, memtoreg_m);
    assign w_need    = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;

    always_comb begin
        w_next_state    = r_state;
        w_next_hold_cnt = r_hold_cnt;
        w_stall         = 1'b0;
        case (r_state)
            c_RUN: begin
                if (w_need != 2'd0) begin
                    w_stall = 1'b1;
                    if (w_need == 2'd2) begin
                        w_next_state    = c_HOLD;
                        w_next_hold_cnt = 2'd1;
                    end
                end
            end
            c_HOLD: begin
                w_stall         = 1'b1;
                w_next_hold_cnt = r_hold_cnt - 2'd1;
                if (r_hold_cnt == 2'd1) begin
                    w_next_state = c_RUN;
                end
            end
            default: begin
                w_next_state    = c_RUN;
                w_next_hold_cnt = 2'd0;
            end
        endcase
    end

    // Stalls are forced low while reset is held so they drop without waiting for an edge.
    assign stall_f      = w_stall & ~rst;
    assign stall_d      = w_stall & ~rst;
    assign flush_e      = w_stall & ~rst;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_RUN;
            r_hold_cnt     <= 2'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_hold_cnt;
            if (stall_d) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_hazard_ctrl
// Description : Directed and randomized bench for branch_hazard_ctrl against a
//               stall-countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_d, rt_d, writereg_e, writereg_m, writereg_w;
    logic [2:0]  branch_d;
    logic        jr_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
    logic [1:0]  fwd_cmp_a, fwd_cmp_b;
    logic        stall_f, stall_d, flush_e;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model state: stall cycles still owed, and the expected counter.
    int          m_left = 0;
    logic [31:0] m_cnt  = '0;

    branch_hazard_ctrl #(.REG_AW(5), .BR_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jr_d(jr_d),
        .writereg_e(writereg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .writereg_w(writereg_w), .regwrite_w(regwrite_w),
        .fwd_cmp_a(fwd_cmp_a), .fwd_cmp_b(fwd_cmp_b), .stall_f(stall_f), .stall_d(stall_d),
        .flush_e(flush_e), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (regwrite_m && !memtoreg_m && writereg_m == src) return 2'b10;
        if (regwrite_w && writereg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int m_need(input logic [4:0] src);
        if (src == 0) return 0;
        if (regwrite_e && writereg_e == src) return memtoreg_e ? 2 : 1;
        if (regwrite_m && memtoreg_m && writereg_m == src) return 1;
        return 0;
    endfunction

    // Compare process: checks every cycle mid-period and advances the model.
    always @(negedge clk) begin
        int  n;
        logic exp_stall;
        chk("fwd_cmp_a", 32'(fwd_cmp_a), 32'(m_fwd(rs_d)));
        chk("fwd_cmp_b", 32'(fwd_cmp_b), 32'(m_fwd(rt_d)));
        if (rst) begin
            m_left    = 0;
            m_cnt     = '0;
            exp_stall = 1'b0;
        end else if (m_left > 0) begin
            exp_stall = 1'b1;
            m_left--;
        end else begin
            n = 0;
            if (branch_d != 0 || jr_d) n = m_need(rs_d);
            if ((branch_d == 1 || branch_d == 2) && m_need(rt_d) > n) n = m_need(rt_d);
            exp_stall = (n > 0);
            m_left    = (n > 0) ? n - 1 : 0;
        end
        chk("stall_f", 32'(stall_f), 32'(exp_stall));
        chk("stall_d", 32'(stall_d), 32'(exp_stall));
        chk("flush_e", 32'(flush_e), 32'(exp_stall));
        chk("stall_cycles", stall_cycles, m_cnt);
        if (!rst && exp_stall) m_cnt = m_cnt + 1;
    end

    task automatic clr();
        rs_d = 0; rt_d = 0; branch_d = 0; jr_d = 0;
        writereg_e = 0; regwrite_e = 0; memtoreg_e = 0;
        writereg_m = 0; regwrite_m = 0; memtoreg_m = 0;
        writereg_w = 0; regwrite_w = 0;
    endtask

    // Move to just after the next rising edge and clear all inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        #3;
        chk("reset stall_d", 32'(stall_d), 32'd0);
        chk("reset stall_cycles", stall_cycles, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // bne on a load in EX: two stalls, then WB forward
        next_cycle();
        branch_d = 3'd2; rs_d = 5'd4;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 5'd4;
        #2 chk("t2 c0 stall_f", 32'(stall_f), 32'd1);
        next_cycle();
        branch_d = 3'd2; rs_d = 5'd4;
        regwrite_m = 1; memtoreg_m = 1; writereg_m = 5'd4;
        #2 chk("t2 c1 stall_d", 32'(stall_d), 32'd1);
        next_cycle();
        branch_d = 3'd2; rs_d = 5'd4;
        regwrite_w = 1; writereg_w = 5'd4;
        #2;
        chk("t2 c2 stall_d", 32'(stall_d), 32'd0);
        chk("t2 c2 fwd_a", 32'(fwd_cmp_a), 32'd1);
        chk("t2 stall_cycles", stall_cycles, 32'd2);

        // beq on an ALU result in EX: one stall, then MEM forward
        next_cycle();
        branch_d = 3'd1; rs_d = 5'd8; rt_d = 5'd9;
        regwrite_e = 1; writereg_e = 5'd8;
        #2 chk("t1 c0 flush_e", 32'(flush_e), 32'd1);
        next_cycle();
        branch_d = 3'd1; rs_d = 5'd8; rt_d = 5'd9;
        regwrite_m = 1; writereg_m = 5'd8;
        #2;
        chk("t1 c1 stall_f", 32'(stall_f), 32'd0);
        chk("t1 c1 fwd_a", 32'(fwd_cmp_a), 32'd2);
        chk("t1 c1 fwd_b", 32'(fwd_cmp_b), 32'd0);

        // jr: MEM beats WB
        next_cycle();
        jr_d = 1; rs_d = 5'd31;
        regwrite_m = 1; writereg_m = 5'd31; regwrite_w = 1; writereg_w = 5'd31;
        #2;
        chk("t3 fwd_a", 32'(fwd_cmp_a), 32'd2);
        chk("t3 stall_d", 32'(stall_d), 32'd0);

        // register 0 never hazards nor forwards
        next_cycle();
        branch_d = 3'd1;
        regwrite_e = 1; memtoreg_e = 1; regwrite_m = 1; regwrite_w = 1;
        #2;
        chk("t4 fwd_a", 32'(fwd_cmp_a), 32'd0);
        chk("t4 fwd_b", 32'(fwd_cmp_b), 32'd0);
        chk("t4 stall_d", 32'(stall_d), 32'd0);

        // rs-only branch ignores rt
        next_cycle();
        branch_d = 3'd3; rs_d = 5'd5; rt_d = 5'd6;
        regwrite_e = 1; writereg_e = 5'd6;
        #2;
        chk("t5 stall_d", 32'(stall_d), 32'd0);
        chk("t5 fwd_b", 32'(fwd_cmp_b), 32'd0);

        // async reset while in HOLD
        next_cycle();
        branch_d = 3'd1; rs_d = 5'd7;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 5'd7;
        next_cycle();
        #2 chk("t6 hold stall_d", 32'(stall_d), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6 rst stall_f", 32'(stall_f), 32'd0);
        chk("t6 rst flush_e", 32'(flush_e), 32'd0);
        chk("t6 rst stall_cycles", stall_cycles, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        branch_d = 3'd1; rs_d = 5'd7;
        #2 chk("t6 after rst stall_d", 32'(stall_d), 32'd0);

        // randomized traffic over a small register set to force collisions
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst        = ($urandom_range(0, 199) == 0);
            rs_d       = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            rt_d       = 5'($urandom_range(0, 3));
            branch_d   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            jr_d       = ($urandom_range(0, 7) == 0);
            writereg_e = 5'($urandom_range(0, 3));
            regwrite_e = 1'($urandom_range(0, 1));
            memtoreg_e = 1'($urandom_range(0, 1));
            writereg_m = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            regwrite_m = 1'($urandom_range(0, 1));
            memtoreg_m = 1'($urandom_range(0, 1));
            writereg_w = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            regwrite_w = 1'($urandom_range(0, 1));
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
